psk_frame_scheduler: RTL and testbench

- Frame sequencer between the TX sample FIFO and the PSK modulator.
- Builds fixed-length frames of preamble bytes, a 2-byte sync word, then payload bytes pulled from the FIFO.
- Presents them to the modulator through the same FIFO-style interface (sample/empty/read) the modulator already consumes.
- Enforces a fixed idle gap between frames and flags payload underruns.

---
 rtl/psk_tx_pkg.sv | 28 ++
 rtl/psk_frame_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_psk_frame_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psk_tx_pkg.sv
// -----------------------------------------------------------------------------
// psk_tx_pkg
// Shared definitions for the PSK transmit path.
//   - psk_tx_state_e : frame scheduler state encoding
//   - PSK_* bytes    : default preamble / sync word / pad values. The RX-side
//                      correlator and the benches use the same values.
//   - psk_max()      : elaboration-time helper for sizing counters
// -----------------------------------------------------------------------------
package psk_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SYNC     = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_GAP      = 3'd4
  } psk_tx_state_e;

  localparam logic [7:0] PSK_PREAMBLE_BYTE = 8'hAA;
  localparam logic [7:0] PSK_SYNC0         = 8'h2D;
  localparam logic [7:0] PSK_SYNC1         = 8'hD4;
  localparam logic [7:0] PSK_PAD_BYTE      = 8'h00;

  function automatic int unsigned psk_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/psk_frame_scheduler.sv
// -----------------------------------------------------------------------------
// psk_frame_scheduler
// Sits between the TX sample FIFO and the PSK modulator. It builds fixed-length
// frames: PREAMBLE_LEN preamble bytes, SYNC0, SYNC1, then PAYLOAD_LEN payload
// bytes pulled from the FIFO. A pad byte replaces each missing payload byte.
// After each frame it waits GAP_CLKS idle cycles.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   enable       permits starting a new frame from IDLE
//   fifo_data    upstream FWFT byte (valid while !fifo_empty)
//   fifo_empty   upstream empty
//   fifo_read    upstream pop (combinational, same cycle as the capture edge)
//   mod_sample   byte offered to the modulator
//   mod_empty    1 = no byte offered
//   mod_read     modulator consumed mod_sample (one-cycle pulse)
//   busy         scheduler is not IDLE
//   frame_done   one-cycle pulse at the end of the inter-frame gap
//   underrun     one-cycle pulse for each padded payload byte
// -----------------------------------------------------------------------------
module psk_frame_scheduler
  import psk_tx_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN  = 4,
  parameter logic [7:0]  PREAMBLE_BYTE = PSK_PREAMBLE_BYTE,
  parameter logic [7:0]  SYNC0         = PSK_SYNC0,
  parameter logic [7:0]  SYNC1         = PSK_SYNC1,
  parameter int unsigned PAYLOAD_LEN   = 16,
  parameter logic [7:0]  PAD_BYTE      = PSK_PAD_BYTE,
  parameter int unsigned GAP_CLKS      = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_read,
  output logic [7:0] mod_sample,
  output logic       mod_empty,
  input  logic       mod_read,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int unsigned BCW = $clog2(psk_max(PREAMBLE_LEN, PAYLOAD_LEN) + 1);
  localparam int unsigned GCW = $clog2(GAP_CLKS + 1);

  localparam logic [BCW-1:0] PRE_LAST = BCW'(PREAMBLE_LEN - 1);
  localparam logic [BCW-1:0] PAY_LAST = BCW'(PAYLOAD_LEN - 1);
  localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_CLKS - 1);

  psk_tx_state_e  state_r, state_n;
  logic [7:0]     hold_r, hold_n;
  logic           hold_valid_r, hold_valid_n;
  logic [BCW-1:0] byte_cnt_r, byte_cnt_n;
  logic [GCW-1:0] gap_cnt_r, gap_cnt_n;
  logic           underrun_r, underrun_n;
  logic           frame_done_r, frame_done_n;
  logic           busy_r;
  logic           consume_s;
  logic           load_payload_s;
  logic           fifo_read_s;

  // State, holding register, counters and pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      hold_r       <= 8'h00;
      hold_valid_r <= 1'b0;
      byte_cnt_r   <= '0;
      gap_cnt_r    <= '0;
      underrun_r   <= 1'b0;
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_n;
      hold_r       <= hold_n;
      hold_valid_r <= hold_valid_n;
      byte_cnt_r   <= byte_cnt_n;
      gap_cnt_r    <= gap_cnt_n;
      underrun_r   <= underrun_n;
      frame_done_r <= frame_done_n;
      busy_r       <= (state_n != ST_IDLE);
    end
  end

  // Next-state logic and frame byte sequencing. The next byte is loaded on the
  // edge that consumes the current one.
  always_comb begin
    state_n        = state_r;
    hold_n         = hold_r;
    hold_valid_n   = hold_valid_r;
    byte_cnt_n     = byte_cnt_r;
    gap_cnt_n      = gap_cnt_r;
    underrun_n     = 1'b0;
    frame_done_n   = 1'b0;
    load_payload_s = 1'b0;
    fifo_read_s    = 1'b0;
    // A read only counts when a byte is actually on offer.
    consume_s      = mod_read && hold_valid_r;

    case (state_r)
      ST_IDLE: begin
        if (enable && !fifo_empty) begin
          hold_n       = PREAMBLE_BYTE;
          hold_valid_n = 1'b1;
          byte_cnt_n   = '0;
          state_n      = ST_PREAMBLE;
        end else begin
          hold_valid_n = 1'b0;
        end
      end
      ST_PREAMBLE: begin
        if (consume_s) begin
          if (byte_cnt_r == PRE_LAST) begin
            hold_n     = SYNC0;
            byte_cnt_n = '0;
            state_n    = ST_SYNC;
          end else begin
            hold_n     = PREAMBLE_BYTE;
            byte_cnt_n = byte_cnt_r + BCW'(1);
          end
        end else begin
          state_n = state_r;
        end
      end
      ST_SYNC: begin
        // byte_cnt 0: SYNC0 on offer; byte_cnt 1: SYNC1 on offer.
        if (consume_s) begin
          if (byte_cnt_r == '0) begin
            hold_n     = SYNC1;
            byte_cnt_n = BCW'(1);
          end else begin
            load_payload_s = 1'b1;
            byte_cnt_n     = '0;
            state_n        = ST_PAYLOAD;
          end
        end else begin
          state_n = state_r;
        end
      end
      ST_PAYLOAD: begin
        // byte_cnt is the index of the payload byte currently on offer.
        if (consume_s) begin
          if (byte_cnt_r == PAY_LAST) begin
            hold_valid_n = 1'b0;
            gap_cnt_n    = '0;
            state_n      = ST_GAP;
          end else begin
            load_payload_s = 1'b1;
            byte_cnt_n     = byte_cnt_r + BCW'(1);
          end
        end else begin
          state_n = state_r;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          frame_done_n = 1'b1;
          state_n      = ST_IDLE;
        end else begin
          gap_cnt_n = gap_cnt_r + GCW'(1);
        end
      end
      default: begin
        state_n      = ST_IDLE;
        hold_valid_n = 1'b0;
      end
    endcase

    // Payload loads take the FIFO head, or pad and flag when it is dry.
    if (load_payload_s) begin
      if (!fifo_empty) begin
        hold_n      = fifo_data;
        fifo_read_s = 1'b1;
      end else begin
        hold_n     = PAD_BYTE;
        underrun_n = 1'b1;
      end
    end else begin
      fifo_read_s = 1'b0;
    end
  end

  assign fifo_read  = fifo_read_s;
  assign mod_sample = hold_r;
  assign mod_empty  = !hold_valid_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign underrun   = underrun_r;

endmodule

// File: tb/tb_psk_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_psk_frame_scheduler
// Self-checking bench for psk_frame_scheduler (PREAMBLE_LEN=2, PAYLOAD_LEN=3,
// GAP_CLKS=8). A modulator model consumes one byte every 16 cycles. A FIFO model
// feeds the payload. Directed table vectors, hand-written corner sequences and
// randomized frames are checked against a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_psk_frame_scheduler;
  import psk_tx_pkg::*;

  localparam int PRE_LEN = 2;
  localparam int PAY_LEN = 3;
  localparam int GAP     = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_read;
  logic [7:0] mod_sample;
  logic       mod_empty;
  logic       mod_read;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  // FIFO model: the bench pushes at tail, pops happen at the DUT's fifo_read.
  logic [7:0] fifo_mem [0:63];
  logic [5:0] fifo_head = 6'd0;
  logic [5:0] fifo_tail = 6'd0;
  assign fifo_data  = fifo_mem[fifo_head];
  assign fifo_empty = (fifo_head == fifo_tail);

  int tests = 0;
  int fails = 0;
  int cyc = 0, last_rd = 0, rd_cnt = 0, ur_cnt = 0, fd_cnt = 0;
  int cool = 0;
  logic [7:0] got[$];
  int gaps[$];
  logic [7:0] stim_q[$];
  logic [7:0] exp_q[$];

  typedef struct packed {
    logic [2:0]       n;
    logic [5:0][7:0]  fifo_in;
    logic [1:0]       frames;
    logic [2:0]       reads;
    logic [2:0]       urs;
    logic [3:0]       exp_len;
    logic [13:0][7:0] exp_bytes;
  } vec_t;
  vec_t vecs[4];

  psk_frame_scheduler #(
    .PREAMBLE_LEN(PRE_LEN),
    .PAYLOAD_LEN (PAY_LEN),
    .GAP_CLKS    (GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .fifo_data (fifo_data),
    .fifo_empty(fifo_empty),
    .fifo_read (fifo_read),
    .mod_sample(mod_sample),
    .mod_empty (mod_empty),
    .mod_read  (mod_read),
    .busy      (busy),
    .frame_done(frame_done),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  // Event monitor: counts pops, underruns, frame ends and the gap length.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mod_read) last_rd <= cyc;
    if (fifo_read) begin
      rd_cnt    <= rd_cnt + 1;
      fifo_head <= fifo_head + 6'd1;
    end
    if (underrun) ur_cnt <= ur_cnt + 1;
    if (frame_done) begin
      fd_cnt <= fd_cnt + 1;
      gaps.push_back(cyc - last_rd);
    end
  end

  // Modulator model: consumes one offered byte, then waits 16 cycles.
  initial begin
    mod_read = 1'b0;
    forever begin
      @(negedge clk);
      mod_read = 1'b0;
      if (cool > 0) cool--;
      else if (!mod_empty) begin
        mod_read = 1'b1;
        got.push_back(mod_sample);
        cool = 15;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[fifo_tail] = b;
    fifo_tail = fifo_tail + 6'd1;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (fd_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (fd_cnt < target) check("frame_timeout", fd_cnt, target);
  endtask

  // Loads stim_q into the FIFO, runs with enable held, compares against exp_q.
  task automatic run_case(input string name, input int e_reads, input int e_urs,
                          input int e_frames);
    int g0, r0, u0, f0, p0;
    @(negedge clk);
    fifo_tail = fifo_head;
    foreach (stim_q[i]) push(stim_q[i]);
    g0 = got.size(); r0 = rd_cnt; u0 = ur_cnt; f0 = fd_cnt; p0 = gaps.size();
    enable = 1'b1;
    wait_frames(f0 + e_frames, 200 * e_frames + 100);
    repeat (30) @(negedge clk);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    check({name, "_len"}, got.size() - g0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (g0 + i < got.size()) check({name, "_byte"}, got[g0 + i], exp_q[i]);
    check({name, "_fifo_reads"}, rd_cnt - r0, e_reads);
    check({name, "_underruns"}, ur_cnt - u0, e_urs);
    check({name, "_frames"}, fd_cnt - f0, e_frames);
    check({name, "_fifo_left"}, int'(6'(fifo_tail - fifo_head)), 0);
    for (int i = p0; i < gaps.size(); i++) check({name, "_gap"}, gaps[i], GAP + 1);
    check({name, "_busy_end"}, busy, 0);
    check({name, "_mod_empty_end"}, mod_empty, 1);
  endtask

  // Frame-level reference: every frame is preamble, sync, then payload from
  // the FIFO contents or pad; frames repeat while the FIFO is non-empty.
  task automatic model(output int e_reads, output int e_urs, output int e_frames);
    logic [7:0] rem[$];
    rem = stim_q;
    exp_q.delete();
    e_reads = 0; e_urs = 0; e_frames = 0;
    while (rem.size() > 0) begin
      for (int k = 0; k < PRE_LEN; k++) exp_q.push_back(PSK_PREAMBLE_BYTE);
      exp_q.push_back(PSK_SYNC0);
      exp_q.push_back(PSK_SYNC1);
      for (int k = 0; k < PAY_LEN; k++) begin
        if (rem.size() > 0) begin
          exp_q.push_back(rem.pop_front());
          e_reads++;
        end else begin
          exp_q.push_back(PSK_PAD_BYTE);
          e_urs++;
        end
      end
      e_frames++;
    end
  endtask

  initial begin
    int er, eu, ef, g0, r0, f0, n;
    logic [7:0] b;

    vecs[0] = '0;
    vecs[0].n = 3'd3; vecs[0].frames = 2'd1; vecs[0].reads = 3'd3; vecs[0].urs = 3'd0;
    vecs[0].fifo_in = {24'h0, 8'h33, 8'h22, 8'h11};
    vecs[0].exp_len = 4'd7;
    vecs[0].exp_bytes = {56'h0, 8'h33, 8'h22, 8'h11, 8'hD4, 8'h2D, 8'hAA, 8'hAA};
    vecs[1] = '0;
    vecs[1].n = 3'd1; vecs[1].frames = 2'd1; vecs[1].reads = 3'd1; vecs[1].urs = 3'd2;
    vecs[1].fifo_in = {40'h0, 8'h11};
    vecs[1].exp_len = 4'd7;
    vecs[1].exp_bytes = {56'h0, 8'h00, 8'h00, 8'h11, 8'hD4, 8'h2D, 8'hAA, 8'hAA};
    vecs[2] = '0;
    vecs[2].n = 3'd6; vecs[2].frames = 2'd2; vecs[2].reads = 3'd6; vecs[2].urs = 3'd0;
    vecs[2].fifo_in = {8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    vecs[2].exp_len = 4'd14;
    vecs[2].exp_bytes = {8'h06, 8'h05, 8'h04, 8'hD4, 8'h2D, 8'hAA, 8'hAA,
                         8'h03, 8'h02, 8'h01, 8'hD4, 8'h2D, 8'hAA, 8'hAA};
    vecs[3] = '0;
    vecs[3].n = 3'd4; vecs[3].frames = 2'd2; vecs[3].reads = 3'd4; vecs[3].urs = 3'd2;
    vecs[3].fifo_in = {16'h0, 8'h5A, 8'h3C, 8'hC3, 8'hA5};
    vecs[3].exp_len = 4'd14;
    vecs[3].exp_bytes = {8'h00, 8'h00, 8'h5A, 8'hD4, 8'h2D, 8'hAA, 8'hAA,
                         8'h3C, 8'hC3, 8'hA5, 8'hD4, 8'h2D, 8'hAA, 8'hAA};

    // Reset values, then release with the FIFO empty.
    rst_n = 1'b1; enable = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_mod_sample", mod_sample, 8'h00);
    check("rst_mod_empty", mod_empty, 1);
    check("rst_fifo_read", fifo_read, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_underrun", underrun, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    repeat (20) @(negedge clk);
    check("empty_fifo_mod_empty", mod_empty, 1);
    check("empty_fifo_busy", busy, 0);
    enable = 1'b0;

    // Directed table.
    for (int v = 0; v < 4; v++) begin
      stim_q.delete(); exp_q.delete();
      for (int i = 0; i < int'(vecs[v].n); i++) stim_q.push_back(vecs[v].fifo_in[i]);
      for (int i = 0; i < int'(vecs[v].exp_len); i++) exp_q.push_back(vecs[v].exp_bytes[i]);
      run_case($sformatf("vec%0d", v), vecs[v].reads, vecs[v].urs, vecs[v].frames);
    end

    // Enable drop during SYNC: the frame completes, no second frame starts.
    @(negedge clk);
    fifo_tail = fifo_head;
    for (int i = 0; i < 6; i++) push(8'hB0 + 8'(i));
    g0 = got.size(); r0 = rd_cnt; f0 = fd_cnt;
    enable = 1'b1;
    n = 0;
    while (!(!mod_empty && mod_sample == PSK_SYNC0) && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) check("drop_sync_timeout", n, 0);
    enable = 1'b0;
    wait_frames(f0 + 1, 300);
    repeat (60) @(negedge clk);
    check("drop_frames", fd_cnt - f0, 1);
    check("drop_len", got.size() - g0, 7);
    check("drop_reads", rd_cnt - r0, 3);
    check("drop_fifo_left", int'(6'(fifo_tail - fifo_head)), 3);
    check("drop_busy", busy, 0);
    if (got.size() >= g0 + 7) begin
      check("drop_pay0", got[g0 + 4], 8'hB0);
      check("drop_pay2", got[g0 + 6], 8'hB2);
    end

    // Reset mid-payload: async clear, then a fresh frame takes the FIFO head.
    @(negedge clk);
    fifo_tail = fifo_head;
    push(8'h11); push(8'h22); push(8'h33);
    enable = 1'b1;
    n = 0;
    while (!(!mod_empty && mod_sample == 8'h22) && n < 300) begin
      @(negedge clk); n++;
    end
    if (n >= 300) check("mid_rst_timeout", n, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_mod_empty", mod_empty, 1);
    check("mid_rst_mod_sample", mod_sample, 8'h00);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_fifo_read", fifo_read, 0);
    repeat (2) @(negedge clk);
    check("mid_rst_fifo_left", int'(6'(fifo_tail - fifo_head)), 1);
    rst_n = 1'b1;
    g0 = got.size(); f0 = fd_cnt; r0 = rd_cnt;
    wait_frames(f0 + 1, 300);
    enable = 1'b0;
    repeat (20) @(negedge clk);
    exp_q = '{8'hAA, 8'hAA, 8'h2D, 8'hD4, 8'h33, 8'h00, 8'h00};
    check("mid_rst_len", got.size() - g0, 7);
    for (int i = 0; i < 7; i++)
      if (g0 + i < got.size()) check("mid_rst_byte", got[g0 + i], exp_q[i]);
    check("mid_rst_reads", rd_cnt - r0, 1);

    // Randomized frames against the reference model.
    for (int it = 0; it < 20; it++) begin
      stim_q.delete();
      n = $urandom_range(0, 7);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        stim_q.push_back(b);
      end
      model(er, eu, ef);
      run_case($sformatf("rand%0d", it), er, eu, ef);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
